// File: rtl/img_stream_tx.sv
// Raster-timed grayscale video source: pulls pixels over valid/ready and emits vsync/href/clken/gray.
// Optional build macro TEST_PATTERN_EN adds pattern_sel for an internal (x+y) test pattern.
module img_stream_tx #(
    parameter logic [10:0] IMG_HDISP = 11'd640,
    parameter logic [10:0] IMG_VDISP = 11'd480,
    parameter logic [3:0]  CLKEN_DIV = 4'd1,
    parameter logic [15:0] H_BLANK   = 16'd160,
    parameter logic [15:0] V_FRONT   = 16'd20,
    parameter logic [15:0] V_BACK    = 16'd20,
    parameter logic [15:0] V_GAP     = 16'd100
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
`ifdef TEST_PATTERN_EN
    input  logic       pattern_sel,
`endif
    input  logic       src_valid,
    input  logic [7:0] src_data,
    output logic       src_ready,
    output logic       per_img_vsync,
    output logic       per_img_href,
    output logic       per_img_clken,
    output logic [7:0] per_img_gray,
    output logic       frame_done,
    output logic       underflow_err,
    output logic [2:0] state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_VFRONT = 3'd1,
        S_LINE   = 3'd2,
        S_HBLANK = 3'd3,
        S_VBACK  = 3'd4,
        S_VGAP   = 3'd5
    } state_t;

    state_t      state, state_nx;
    logic [15:0] cnt, cnt_nx;
    logic [10:0] x, x_nx, y, y_nx;
    logic [3:0]  div, div_nx;
    logic        start_frame;
    logic        frame_end;
    logic        slot;
    logic        pat_mode;

    assign state_dbg = state;

    // Handshake: src_ready marks a pixel slot and depends only on state and
    // divider; a pixel is consumed when src_valid && src_ready. The raster
    // never waits for src_valid, a missing pixel becomes 0 and underflow.
    assign slot      = (state == S_LINE) && (div == 4'd0);
    assign src_ready = slot && !pat_mode;

`ifdef TEST_PATTERN_EN
    logic pat_q;
    assign pat_mode = pat_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pat_q <= 1'b0;
        end else if (start_frame) begin
            pat_q <= pattern_sel;
        end
    end
`else
    assign pat_mode = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= 16'd0;
            x     <= 11'd0;
            y     <= 11'd0;
            div   <= 4'd0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            x     <= x_nx;
            y     <= y_nx;
            div   <= div_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt + 16'd1;
        x_nx        = x;
        y_nx        = y;
        div_nx      = div;
        start_frame = 1'b0;
        frame_end   = 1'b0;
        case (state)
            S_IDLE: begin
                cnt_nx = 16'd0;
                if (enable) begin
                    state_nx    = S_VFRONT;
                    start_frame = 1'b1;
                end
            end
            S_VFRONT: begin
                if (cnt == V_FRONT - 16'd1) begin
                    state_nx = S_LINE;
                    cnt_nx   = 16'd0;
                    x_nx     = 11'd0;
                    y_nx     = 11'd0;
                    div_nx   = 4'd0;
                end
            end
            S_LINE: begin
                cnt_nx = 16'd0;
                if (div == CLKEN_DIV - 4'd1) begin
                    div_nx = 4'd0;
                    if (x == IMG_HDISP - 11'd1) begin
                        x_nx     = 11'd0;
                        state_nx = (y == IMG_VDISP - 11'd1) ? S_VBACK : S_HBLANK;
                    end else begin
                        x_nx = x + 11'd1;
                    end
                end else begin
                    div_nx = div + 4'd1;
                end
            end
            S_HBLANK: begin
                if (cnt == H_BLANK - 16'd1) begin
                    state_nx = S_LINE;
                    cnt_nx   = 16'd0;
                    x_nx     = 11'd0;
                    y_nx     = y + 11'd1;
                    div_nx   = 4'd0;
                end
            end
            S_VBACK: begin
                if (cnt == V_BACK - 16'd1) begin
                    state_nx  = S_VGAP;
                    cnt_nx    = 16'd0;
                    frame_end = 1'b1;
                end
            end
            S_VGAP: begin
                if (cnt == V_GAP - 16'd1) begin
                    cnt_nx = 16'd0;
                    if (enable) begin
                        state_nx    = S_VFRONT;
                        start_frame = 1'b1;
                    end else begin
                        state_nx = S_IDLE;
                    end
                end
            end
            default: begin
                state_nx = S_IDLE;
                cnt_nx   = 16'd0;
            end
        endcase
    end

    // Outputs are registered from the current state, one clock behind it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            per_img_vsync <= 1'b0;
            per_img_href  <= 1'b0;
            per_img_clken <= 1'b0;
            per_img_gray  <= 8'd0;
            frame_done    <= 1'b0;
            underflow_err <= 1'b0;
        end else begin
            per_img_vsync <= (state != S_IDLE) && (state != S_VGAP);
            per_img_href  <= (state == S_LINE);
            per_img_clken <= slot;
            frame_done    <= frame_end;
            if (slot) begin
                if (pat_mode) begin
                    per_img_gray <= x[7:0] + y[7:0];
                end else begin
                    per_img_gray <= src_valid ? src_data : 8'd0;
                end
            end
            if (start_frame) begin
                underflow_err <= 1'b0;
            end else if (slot && !src_valid && !pat_mode) begin
                underflow_err <= 1'b1;
            end
        end
    end

endmodule
